fc_argmax_stream: RTL and testbench
===================================

Name: fc_argmax_stream

Overview:
- Parametrised streaming argmax unit for the FC output stage. It is the successor of the fixed 10-entry, 16-bit comparator.
- Accepts one class score per cycle over a valid/ready handshake.
- Reports the winning index, the runner-up index and the winning score.
- Holds the result until the downstream stage acknowledges it. Back-to-back frames are supported.

Parameters:
- DATA_WIDTH, 16, bit width of each class score.
- NUM_CLASSES, 10, scores per frame (>=1).
- SIGNED, 1, 1 = scores are two's complement fixed point; 0 = unsigned compare.
- IDX_W, max(1, clog2(NUM_CLASSES)), index width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  start-of-frame request.
- in_valid  in  1  score valid.
- in_data  in  DATA_WIDTH  class score; index = arrival order.
- in_ready  out  1  unit accepts a score this cycle.
- done  out  1  result valid; held until out_ready.
- out_ready  in  1  downstream acknowledge.
- result  out  IDX_W  index of the maximum score.
- second_result  out  IDX_W  index of the second-largest score.
- max_value  out  DATA_WIDTH  maximum score.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- Reset values: state=IDLE, in_ready=0, done=0, result=0, second_result=0, max_value=0, element count=0.
- States:
  - IDLE: in_ready=0. enable=1 -> SCAN (count cleared).
  - SCAN: in_ready=1. A beat is accepted when in_valid && in_ready. enable is ignored in SCAN.
  - DONE: in_ready=0, done=1, outputs stable.
    - out_ready=1 and enable=0 -> IDLE.
    - out_ready=1 and enable=1 -> SCAN (back-to-back frame).
    - out_ready=0 -> stay in DONE; enable is ignored.
- Compare rules:
  - Beat 0: best=data, best_idx=0, second_idx=0, second_valid=0.
  - Beat k>0, data > best: second<=best, second_idx<=best_idx, second_valid<=1, best<=data, best_idx<=k.
  - Otherwise, if !second_valid or data > second: second<=data, second_idx<=k, second_valid<=1.
  - Comparison is strict greater-than, signed or unsigned per SIGNED. On a tie the lower index wins for both best and second.
- Completion and latency:
  - Accepting beat NUM_CLASSES-1 transitions to DONE.
  - result, second_result and max_value update on that same edge; done=1 from the next cycle.
  - With in_valid held high: enable at cycle 0 gives SCAN at cycle 1, beats accepted at cycles 1..N, done at cycle N+1.
- Result hold: result, second_result and max_value keep their values after done drops, until the next frame completes.
- Input gaps: bubbles (in_valid=0) in SCAN stall the count and do not alter state.
- Index counter: counts 0..NUM_CLASSES-1 and does not wrap within a frame.
- NUM_CLASSES=1: result=0, second_result=0, max_value=the single score.
- reset mid-operation (any state): frame abandoned, all outputs return to reset values on the next edge, partial results discarded.
- No internal arithmetic overflow is possible; compare only.

Test Plan:
- Frame {0x0800,0x0000,0x0001,0x0002,0x0004,0x0008,0x0010,0x0020,0x0040,0x0080}, in_valid continuous -> done at cycle 11 after enable; result=0, second_result=9, max_value=0x0800.
- SIGNED=1, all-negative frame {0xFFF0,0xFFFE,0x8000,0xFFFF,0xFF00,...(rest 0x8000)} -> result=3, second_result=1, max_value=0xFFFF. The same frame with SIGNED=0 -> result=3, max_value=0xFFFF, second_result=1.
- Ties: 0x0100 at indices 3 and 7, all others 0 -> result=3, second_result=7.
- Backpressure:
  - in_valid low for 2 cycles after beat 4 -> count holds, final result unchanged.
  - out_ready held low 5 cycles -> done and outputs stable, in_ready=0.
  - Then out_ready=1 -> IDLE, done=0.
- reset asserted after 4 accepted beats -> next cycle all outputs 0, state IDLE; a fresh frame then yields the correct result.
- Back-to-back frames: out_ready=1 and enable=1 in the same DONE cycle -> SCAN next cycle, no lost beat.
- Variant NUM_CLASSES=16, DATA_WIDTH=8, SIGNED=0, index 15=0xFF, others<0xFF -> result=15 (IDX_W=4).

Source files
------------

// File: rtl/fc_argmax_stream.sv
// Streaming argmax for the FC output stage: one score per beat, reports the
// winning index, the runner-up index and the winning score, held until acknowledged.
module fc_argmax_stream #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int SIGNED      = 1,
    localparam int IDX_W      = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  done,
    input  logic                  out_ready,
    output logic [IDX_W-1:0]      result,
    output logic [IDX_W-1:0]      second_result,
    output logic [DATA_WIDTH-1:0] max_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t state, state_nxt;

    logic [IDX_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] best, second;
    logic [IDX_W-1:0]      best_idx, second_idx;
    logic                  second_valid;

    logic [DATA_WIDTH-1:0] best_nxt, second_nxt;
    logic [IDX_W-1:0]      best_idx_nxt, second_idx_nxt;
    logic                  second_valid_nxt;

    logic accept;
    logic last_beat;

    // Strict greater-than; equal scores never displace an earlier index.
    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        if (SIGNED != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    assign in_ready  = (state == S_SCAN);
    assign done      = (state == S_DONE);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == LAST_IDX);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (enable) state_nxt = S_SCAN;
            S_SCAN: if (accept && last_beat) state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = enable ? S_SCAN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        best_nxt         = best;
        best_idx_nxt     = best_idx;
        second_nxt       = second;
        second_idx_nxt   = second_idx;
        second_valid_nxt = second_valid;
        if (cnt == '0) begin
            best_nxt         = in_data;
            best_idx_nxt     = '0;
            second_idx_nxt   = '0;
            second_valid_nxt = 1'b0;
        end else if (gt(in_data, best)) begin
            second_nxt       = best;
            second_idx_nxt   = best_idx;
            second_valid_nxt = 1'b1;
            best_nxt         = in_data;
            best_idx_nxt     = cnt;
        end else if (!second_valid || gt(in_data, second)) begin
            second_nxt       = in_data;
            second_idx_nxt   = cnt;
            second_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cnt           <= '0;
            best          <= '0;
            best_idx      <= '0;
            second        <= '0;
            second_idx    <= '0;
            second_valid  <= 1'b0;
            result        <= '0;
            second_result <= '0;
            max_value     <= '0;
        end else begin
            state <= state_nxt;

            // Count is cleared outside SCAN and saturates on the final beat.
            if (state != S_SCAN)
                cnt <= '0;
            else if (accept && !last_beat)
                cnt <= cnt + IDX_W'(1);

            if (accept) begin
                best         <= best_nxt;
                best_idx     <= best_idx_nxt;
                second       <= second_nxt;
                second_idx   <= second_idx_nxt;
                second_valid <= second_valid_nxt;
                if (last_beat) begin
                    result        <= best_idx_nxt;
                    second_result <= second_idx_nxt;
                    max_value     <= best_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax_stream.sv
// Directed bench for fc_argmax_stream: default signed instance, an unsigned
// twin sharing its inputs, and a 16-class 8-bit unsigned variant.
module tb_fc_argmax_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    logic        in_ready, done;
    logic [3:0]  result, second_result;
    logic [15:0] max_value;

    logic        u_in_ready, u_done;
    logic [3:0]  u_result, u_second_result;
    logic [15:0] u_max_value;

    logic        v_enable, v_in_valid, v_out_ready;
    logic [7:0]  v_in_data;
    logic        v_in_ready, v_done;
    logic [3:0]  v_result, v_second_result;
    logic [7:0]  v_max_value;

    logic [15:0] frame [10];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fc_argmax_stream dut (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .done(done), .out_ready(out_ready),
        .result(result), .second_result(second_result), .max_value(max_value)
    );

    fc_argmax_stream #(.DATA_WIDTH(16), .NUM_CLASSES(10), .SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(u_in_ready), .done(u_done), .out_ready(out_ready),
        .result(u_result), .second_result(u_second_result), .max_value(u_max_value)
    );

    fc_argmax_stream #(.DATA_WIDTH(8), .NUM_CLASSES(16), .SIGNED(0)) dut_v (
        .clk(clk), .reset(reset), .enable(v_enable), .in_valid(v_in_valid),
        .in_data(v_in_data), .in_ready(v_in_ready), .done(v_done), .out_ready(v_out_ready),
        .result(v_result), .second_result(v_second_result), .max_value(v_max_value)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] r, input logic [3:0] s,
                                input logic [15:0] m);
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".result"}, 32'(result), 32'(r));
        chk({tag, ".second"}, 32'(second_result), 32'(s));
        chk({tag, ".max"}, 32'(max_value), 32'(m));
    endtask

    // Called at a negedge while IDLE; returns at the negedge where SCAN is visible.
    task automatic begin_frame();
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Streams frame[]; optionally inserts gap_len bubbles after beat gap_after.
    // Returns at the negedge following the final accepting edge.
    task automatic feed(input int gap_after, input int gap_len);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i];
            chk($sformatf("beat%0d.in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("beat%0d.done", i), 32'(done), 32'd0);
            @(negedge clk);
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    in_valid = 1'b0;
                    in_data  = 16'h7FFF;
                    chk("gap.in_ready", 32'(in_ready), 32'd1);
                    chk("gap.done", 32'(done), 32'd0);
                    @(negedge clk);
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b1;
        v_enable    = 1'b0;
        v_in_valid  = 1'b0;
        v_in_data   = '0;
        v_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst.in_ready", 32'(in_ready), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", 32'(result), 32'd0);
        chk("rst.second", 32'(second_result), 32'd0);
        chk("rst.max", 32'(max_value), 32'd0);
        chk("rst.u_done", 32'(u_done), 32'd0);
        chk("rst.v_result", 32'(v_result), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle.in_ready", 32'(in_ready), 32'd0);

        // Large first score, small ascending tail: runner-up is the last beat.
        frame = '{16'h0800, 16'h0000, 16'h0001, 16'h0002, 16'h0004,
                  16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
        begin_frame();
        feed(-1, 0);
        check_result("frameA", 4'd0, 4'd9, 16'h0800);
        @(negedge clk);
        chk("frameA.done_drop", 32'(done), 32'd0);
        chk("frameA.idle_ready", 32'(in_ready), 32'd0);
        chk("frameA.hold_result", 32'(result), 32'd0);
        chk("frameA.hold_second", 32'(second_result), 32'd9);
        chk("frameA.hold_max", 32'(max_value), 32'h0800);

        // All-negative in signed view; same winners under unsigned compare.
        frame = '{16'hFFF0, 16'hFFFE, 16'h8000, 16'hFFFF, 16'hFF00,
                  16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        begin_frame();
        feed(-1, 0);
        check_result("neg", 4'd3, 4'd1, 16'hFFFF);
        chk("negU.done", 32'(u_done), 32'd1);
        chk("negU.result", 32'(u_result), 32'd3);
        chk("negU.second", 32'(u_second_result), 32'd1);
        chk("negU.max", 32'(u_max_value), 32'hFFFF);
        @(negedge clk);

        // Ties with a two-bubble gap after beat 4, then a five-cycle stall.
        frame = '{16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000,
                  16'h0000, 16'h0000, 16'h0100, 16'h0000, 16'h0000};
        out_ready = 1'b0;
        begin_frame();
        feed(4, 2);
        check_result("ties", 4'd3, 4'd7, 16'h0100);
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall.done", 32'(done), 32'd1);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
            chk("stall.result", 32'(result), 32'd3);
            chk("stall.second", 32'(second_result), 32'd7);
            chk("stall.max", 32'(max_value), 32'h0100);
        end
        enable    = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release.done", 32'(done), 32'd0);
        chk("release.in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("release.idle", 32'(in_ready), 32'd0);

        // Abandon a frame after four beats.
        begin_frame();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h7000 + 16'(i);
            @(negedge clk);
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst.in_ready", 32'(in_ready), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.result", 32'(result), 32'd0);
        chk("midrst.second", 32'(second_result), 32'd0);
        chk("midrst.max", 32'(max_value), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst.idle", 32'(in_ready), 32'd0);

        frame = '{16'd5, 16'd9, 16'd3, 16'd9, 16'd1,
                  16'd2, 16'd8, 16'd7, 16'd6, 16'd0};
        begin_frame();
        feed(-1, 0);
        check_result("fresh", 4'd1, 4'd3, 16'd9);
        @(negedge clk);

        // Back-to-back: enable and out_ready together in the DONE cycle.
        for (int i = 0; i < 10; i++) frame[i] = 16'(i * 16);
        begin_frame();
        feed(-1, 0);
        check_result("b2b1", 4'd9, 4'd8, 16'h0090);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        chk("b2b.in_ready", 32'(in_ready), 32'd1);
        chk("b2b.done", 32'(done), 32'd0);
        frame = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5,
                  16'd9, 16'd2, 16'd6, 16'd5, 16'd3};
        feed(-1, 0);
        check_result("b2b2", 4'd5, 4'd7, 16'd9);
        @(negedge clk);

        // 16-class, 8-bit unsigned variant: maximum at the last index.
        v_enable = 1'b1;
        @(negedge clk);
        v_enable = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v_in_valid = 1'b1;
            v_in_data  = (i == 15) ? 8'hFF : 8'(i * 3);
            chk("v.in_ready", 32'(v_in_ready), 32'd1);
            @(negedge clk);
        end
        v_in_valid = 1'b0;
        chk("v.done", 32'(v_done), 32'd1);
        chk("v.result", 32'(v_result), 32'd15);
        chk("v.second", 32'(v_second_result), 32'd14);
        chk("v.max", 32'(v_max_value), 32'hFF);
        @(negedge clk);
        chk("v.done_drop", 32'(v_done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
